load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage between the ALU and the register bank. It takes the ALU address (alu_out), store data (rs2_data), funct3 and rd for one load/store instruction. It runs a req/ack transaction with data memory and does byte/half/word lane steering. For loads it drives the register bank's data_in, rd and save_from_memory; for stores it only touches memory.

Parameters:
MEM_TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before a fault is raised (valid range 1..255).

Ports:
stage_clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (sampled on the stage_clk rising edge; 0 = reset)
start  input  1  one-cycle request to run one access; ignored while busy
is_store  input  1  1 = store (SB/SH/SW), 0 = load (LB/LH/LW/LBU/LHU)
funct3  input  3  RISC-V funct3 width/sign code
addr  input  32  byte address from ALU
store_data  input  32  rs2 value
rd_in  input  5  load destination register
mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  32  store data replicated across lanes
mem_wstrb  output  4  byte-enable for stores; 0000 for loads
mem_we  output  1  1 during store transactions
mem_req  output  1  request, held until mem_ack or timeout
mem_rdata  input  32  read word, valid when mem_ack=1
mem_ack  input  1  memory completion, one cycle
load_data  output  32  extended load result to register bank data_in
rd_out  output  5  latched rd to register bank
save_from_memory  output  1  one-cycle writeback strobe
busy  output  1  high from the cycle after start until IDLE is re-entered
done  output  1  one-cycle pulse on successful completion (loads and stores)
fault  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, timeout counter=0. All outputs go to 0, including load_data, rd_out and mem_addr.
- Reset mid-transaction: mem_req drops at that edge; the access is abandoned and there is no done/fault pulse.
- States: IDLE, REQ, DONE, FAULT.
- IDLE:
  - On start=1, latch is_store, funct3, addr, store_data and rd_in.
  - Illegal funct3 or misalignment -> FAULT. Illegal funct3: loads 011/110/111; stores >010.
  - Misalignment: half with addr[0]=1, or word with addr[1:0]!=00.
  - Otherwise -> REQ.
- REQ:
  - mem_req=1, mem_addr/mem_we/mem_wstrb/mem_wdata stable for the whole state.
  - Counter increments each cycle mem_ack=0.
  - mem_ack=1 -> DONE; a load captures the extracted, extended data at this edge.
  - Counter reaching MEM_TIMEOUT with no ack -> FAULT.
  - mem_ack outside REQ is ignored.
- DONE: done=1 for one cycle; for loads, save_from_memory=1 in the same cycle. Next state IDLE.
- FAULT: fault=1 for one cycle, with no memory access for alignment/funct3 faults and no writeback. Next state IDLE.
- Latency:
  - start in cycle 0 -> mem_req in cycle 1.
  - ack in cycle k -> done in cycle k+1.
  - A zero-wait memory (ack in cycle 1) gives done in cycle 2.
  - Back-to-back: start is accepted again in the cycle after done.
- Store steering:
  - SB: wstrb=0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: wstrb=0011<<(2*addr[1]), wdata={2{sd[15:0]}}.
  - SW: wstrb=1111, wdata=sd.
- Load extraction:
  - Select byte addr[1:0] or half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- load_data and rd_out hold their last values until the next successful load; stores and faults do not modify them.
- A load with rd_in=0 still pulses save_from_memory. The register bank keeps x0 at zero.
- busy=1 in REQ/DONE/FAULT; a start seen while busy is dropped, not queued.

Decomposition:
- Shared package/include: funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101) and state encodings (IDLE/REQ/DONE/FAULT); the decoder and control FSM reuse them.
- One natural sub-module: lsu_lane_steer, purely combinational. It maps funct3, addr[1:0], store_data and mem_rdata to wstrb, wdata and extended load data. The FSM remains in load_store_unit.

Test Plan:
- LW addr=0x100, memory acks in cycle 1 with 0xDEADBEEF, rd_in=5 -> mem_addr=0x100, wstrb=0000; cycle 2: done=1, save_from_memory=1, load_data=0xDEADBEEF, rd_out=5.
- LB/LBU addr=0x103, rdata=0x80112233 -> LB load_data=0xFFFFFF80; LBU load_data=0x00000080.
- SH addr=0x202, store_data=0x1234ABCD, ack after 3 wait cycles -> mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1, req held 4 cycles, done=1, save_from_memory=0, load_data unchanged.
- LW addr=0x101 -> fault=1 in cycle 1, mem_req never asserted, save_from_memory=0.
- MEM_TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then fault=1, busy drops the following cycle; a later start succeeds normally.
- reset=0 asserted while in REQ -> next edge: mem_req=0, busy=0, load_data=0, no done/fault pulse; a start during busy is ignored (no second transaction).

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared funct3 codes, control FSM states and access-legality helpers for the load/store unit.
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDone,
      StFault
   } lsu_state_e;

   function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
      if (is_store) return (f3 > F3_W);
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

   // Access size comes from funct3[1:0] for both signed and unsigned loads.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      case (f3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return |addr_lo;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_we;
   logic        mem_req;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_addr, mem_wdata, mem_wstrb, mem_we, mem_req,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_wstrb, mem_we, mem_req,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/lsu_lane_steer.sv
// Byte/half/word lane steering: store strobes and replicated write data, load extraction and
// sign/zero extension. Purely combinational.
module lsu_lane_steer
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      unique case (i_addr_lo)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_wstrb     = 4'b0000;
      o_wdata     = i_store_data;
      o_load_data = i_rdata;
      case (i_funct3)
         F3_B: begin
            o_wstrb     = 4'b0001 << i_addr_lo;
            o_wdata     = {4{i_store_data[7:0]}};
            o_load_data = {{24{w_byte[7]}}, w_byte};
         end
         F3_H: begin
            o_wstrb     = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata     = {2{i_store_data[15:0]}};
            o_load_data = {{16{w_half[15]}}, w_half};
         end
         F3_W:    o_wstrb     = 4'b1111;
         F3_BU:   o_load_data = {24'd0, w_byte};
         F3_HU:   o_load_data = {16'd0, w_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one req/ack data-memory transaction per load/store and hands
// extended load results to the register bank.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                     i_stage_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic                     i_is_store,
   input  logic [2:0]               i_funct3,
   input  logic [31:0]              i_addr,
   input  logic [31:0]              i_store_data,
   input  logic [4:0]               i_rd_in,
   load_store_unit_if.master        io_mem,
   output logic [31:0]              o_load_data,
   output logic [4:0]               o_rd_out,
   output logic                     o_save_from_memory,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_fault
);

   lsu_state_e  r_state, w_state_next;
   logic        r_is_store;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_store_data;
   logic [4:0]  r_rd;
   logic [7:0]  r_cnt;
   logic [31:0] r_load_data;
   logic [4:0]  r_rd_out;

   logic [7:0]  w_cnt_inc;
   logic        w_timeout;
   logic        w_bad_access;
   logic        w_in_req;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [31:0] w_load_ext;

   assign w_cnt_inc    = r_cnt + 8'd1;
   assign w_timeout    = (w_cnt_inc == 8'(MEM_TIMEOUT));
   assign w_bad_access = f3_illegal(i_is_store, i_funct3) || misaligned(i_funct3, i_addr[1:0]);
   assign w_in_req     = (r_state == StReq);

   lsu_lane_steer u_lane_steer (
      .i_funct3     (r_funct3),
      .i_addr_lo    (r_addr[1:0]),
      .i_store_data (r_store_data),
      .i_rdata      (io_mem.mem_rdata),
      .o_wstrb      (w_wstrb),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_ext)
   );

   // Decoding the raw inputs lets a bad access fault in the cycle right after start.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_next = w_bad_access ? StFault : StReq;
         StReq: begin
            if (io_mem.mem_ack)  w_state_next = StDone;
            else if (w_timeout)  w_state_next = StFault;
         end
         StDone:  w_state_next = StIdle;
         StFault: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_stage_clk) begin
      if (!i_reset) begin
         r_state      <= StIdle;
         r_is_store   <= 1'b0;
         r_funct3     <= 3'd0;
         r_addr       <= 32'd0;
         r_store_data <= 32'd0;
         r_rd         <= 5'd0;
         r_cnt        <= 8'd0;
         r_load_data  <= 32'd0;
         r_rd_out     <= 5'd0;
      end else begin
         r_state <= w_state_next;
         if (r_state == StIdle && i_start) begin
            r_is_store   <= i_is_store;
            r_funct3     <= i_funct3;
            r_addr       <= i_addr;
            r_store_data <= i_store_data;
            r_rd         <= i_rd_in;
            r_cnt        <= 8'd0;
         end
         if (w_in_req && !io_mem.mem_ack) r_cnt <= w_cnt_inc;
         if (w_in_req && io_mem.mem_ack && !r_is_store) begin
            r_load_data <= w_load_ext;
            r_rd_out    <= r_rd;
         end
      end
   end

   assign io_mem.mem_req   = w_in_req;
   assign io_mem.mem_we    = w_in_req && r_is_store;
   assign io_mem.mem_wstrb = (w_in_req && r_is_store) ? w_wstrb : 4'b0000;
   assign io_mem.mem_addr  = {r_addr[31:2], 2'b00};
   assign io_mem.mem_wdata = w_wdata;

   assign o_load_data        = r_load_data;
   assign o_rd_out           = r_rd_out;
   assign o_busy             = (r_state != StIdle);
   assign o_done             = (r_state == StDone);
   assign o_save_from_memory = (r_state == StDone) && !r_is_store;
   assign o_fault            = (r_state == StFault);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a transaction-level model checked every cycle plus directed
// vectors with hand-computed expectations.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int unsigned TIMEOUT = 4;

   typedef struct {
      int          req_n;
      int          done_c;
      int          fault_c;
      int          save_c;
      int          end_c;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] maddr;
      logic        we;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  f3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] sd = 32'd0;
   logic [4:0]  rd = 5'd0;
   logic [31:0] load_data;
   logic [4:0]  rd_out;
   logic        save, busy, done, fault;

   int n_checks = 0;
   int n_errors = 0;

   load_store_unit_if mem_bus ();

   load_store_unit #(.MEM_TIMEOUT(TIMEOUT)) u_dut (
      .i_stage_clk        (clk),
      .i_reset            (rst_n),
      .i_start            (start),
      .i_is_store         (is_store),
      .i_funct3           (f3),
      .i_addr             (addr),
      .i_store_data       (sd),
      .i_rd_in            (rd),
      .io_mem             (mem_bus),
      .o_load_data        (load_data),
      .o_rd_out           (rd_out),
      .o_save_from_memory (save),
      .o_busy             (busy),
      .o_done             (done),
      .o_fault            (fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   function automatic bit m_bad(input bit st, input logic [2:0] fn, input logic [1:0] a);
      int sz;
      if (st ? (fn > 3'd2) : (fn == 3'd3 || fn >= 3'd6)) return 1'b1;
      sz = 1 << fn[1:0];
      return (int'(a) % sz) != 0;
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] fn, input logic [1:0] a);
      int sz;
      sz = 1 << fn[1:0];
      return 4'(((1 << sz) - 1) << a);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] fn, input logic [31:0] d);
      if (fn == 3'd0) return d[7:0] * 32'h01010101;
      if (fn == 3'd1) return d[15:0] * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [1:0] a,
                                          input logic [31:0] w);
      logic [31:0] sh;
      int v;
      sh = w >> (8 * a);
      case (fn)
         3'd0: begin v = int'(sh & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
         3'd1: begin v = int'(sh & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
         3'd4: return sh & 32'hFF;
         3'd5: return sh & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   bit          e_req, e_done, e_fault, e_save, e_store;
   bit [2:0]    e_f3;
   bit [31:0]   e_addr, e_sd, e_load;
   bit [4:0]    e_rd, e_rd_out;
   int          e_wait;

   always @(posedge clk) begin
      if (!rst_n) begin
         e_req = 0; e_done = 0; e_fault = 0; e_save = 0; e_store = 0;
         e_f3 = 0; e_addr = 0; e_sd = 0; e_load = 0; e_rd = 0; e_rd_out = 0; e_wait = 0;
      end else if (e_done || e_fault) begin
         e_done = 0; e_fault = 0; e_save = 0;
      end else if (e_req) begin
         if (mem_bus.mem_ack) begin
            e_req  = 0;
            e_done = 1;
            e_save = !e_store;
            if (!e_store) begin
               e_load   = m_load(e_f3, e_addr[1:0], mem_bus.mem_rdata);
               e_rd_out = e_rd;
            end
         end else begin
            e_wait++;
            if (e_wait == TIMEOUT) begin
               e_req   = 0;
               e_fault = 1;
            end
         end
      end else if (start) begin
         e_store = is_store; e_f3 = f3; e_addr = addr; e_sd = sd; e_rd = rd; e_wait = 0;
         if (m_bad(is_store, f3, addr[1:0])) e_fault = 1;
         else e_req = 1;
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(e_req | e_done | e_fault));
      check("done", 32'(done), 32'(e_done));
      check("fault", 32'(fault), 32'(e_fault));
      check("save_from_memory", 32'(save), 32'(e_save));
      check("mem_req", 32'(mem_bus.mem_req), 32'(e_req));
      check("load_data", load_data, e_load);
      check("rd_out", 32'(rd_out), 32'(e_rd_out));
      if (e_req) begin
         check("mem_addr", mem_bus.mem_addr, {e_addr[31:2], 2'b00});
         check("mem_we", 32'(mem_bus.mem_we), 32'(e_store));
         check("mem_wstrb", 32'(mem_bus.mem_wstrb), e_store ? 32'(m_strb(e_f3, e_addr[1:0])) : 0);
         if (e_store) check("mem_wdata", mem_bus.mem_wdata, m_wdata(e_f3, e_sd));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // w: wait cycles before ack (negative = never); poke: cycle in which a stray start is issued.
   task automatic access(input bit st, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r, input logic [31:0] rdata,
                         input int w, input int poke, output obs_t o);
      bit finished;
      o = '{req_n: 0, done_c: -1, fault_c: -1, save_c: -1, end_c: -1,
            strb: 4'h0, wdata: 32'h0, maddr: 32'h0, we: 1'b0};
      finished = 0;
      is_store = st; f3 = fn; addr = a; sd = d; rd = r; start = 1'b1;
      tick();
      for (int c = 1; c <= 40 && !finished; c++) begin
         start = (c == poke);
         if (c == poke) begin addr = 32'h300; rd = 5'd9; end
         if (!busy) begin
            o.end_c  = c;
            finished = 1;
         end else begin
            mem_bus.mem_ack   = (c == w + 1);
            mem_bus.mem_rdata = (c == w + 1) ? rdata : 32'hBAD0BAD0;
            if (mem_bus.mem_req) begin
               o.req_n++;
               o.strb  = mem_bus.mem_wstrb;
               o.wdata = mem_bus.mem_wdata;
               o.maddr = mem_bus.mem_addr;
               o.we    = mem_bus.mem_we;
            end
            if (done) o.done_c = c;
            if (fault) o.fault_c = c;
            if (save) o.save_c = c;
            tick();
            mem_bus.mem_ack = 1'b0;
         end
      end
      start = 1'b0;
      check("txn_completes", 32'(finished), 32'd1);
   endtask

   obs_t o;

   initial begin
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      repeat (2) tick();
      check("rst_load_data", load_data, 32'h0);
      check("rst_rd_out", 32'(rd_out), 32'h0);
      check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();

      access(0, F3_W, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, o);
      check("lw_req_n", o.req_n, 1);
      check("lw_done_cycle", o.done_c, 2);
      check("lw_save_cycle", o.save_c, 2);
      check("lw_mem_addr", o.maddr, 32'h100);
      check("lw_wstrb", 32'(o.strb), 32'h0);
      check("lw_data", load_data, 32'hDEADBEEF);
      check("lw_rd", 32'(rd_out), 32'd5);

      access(0, F3_B, 32'h103, 32'h0, 5'd6, 32'h80112233, 1, 0, o);
      check("lb_data", load_data, 32'hFFFFFF80);
      check("lb_mem_addr", o.maddr, 32'h100);
      access(0, F3_BU, 32'h103, 32'h0, 5'd7, 32'h80112233, 0, 0, o);
      check("lbu_data", load_data, 32'h00000080);

      access(1, F3_H, 32'h202, 32'h1234ABCD, 5'd11, 32'h0, 3, 0, o);
      check("sh_wstrb", 32'(o.strb), 32'hC);
      check("sh_wdata", o.wdata, 32'hABCDABCD);
      check("sh_we", 32'(o.we), 32'd1);
      check("sh_req_n", o.req_n, 4);
      check("sh_done_cycle", o.done_c, 5);
      check("sh_no_save", o.save_c, -1);
      check("sh_data_held", load_data, 32'h00000080);
      check("sh_rd_held", 32'(rd_out), 32'd7);

      access(0, F3_W, 32'h101, 32'h0, 5'd3, 32'h0, -1, 0, o);
      check("mis_fault_cycle", o.fault_c, 1);
      check("mis_req_n", o.req_n, 0);
      check("mis_no_save", o.save_c, -1);

      access(0, F3_W, 32'h104, 32'h0, 5'd4, 32'h0, -1, 0, o);
      check("to_req_n", o.req_n, 4);
      check("to_fault_cycle", o.fault_c, 5);
      check("to_idle_cycle", o.end_c, 6);
      check("to_data_held", load_data, 32'h00000080);

      access(0, F3_H, 32'h106, 32'h0, 5'd12, 32'h80017FFF, 2, 2, o);
      check("lh_req_n", o.req_n, 3);
      check("lh_done_cycle", o.done_c, 4);
      check("lh_data", load_data, 32'hFFFF8001);
      check("lh_rd", 32'(rd_out), 32'd12);
      repeat (3) tick();
      check("stray_start_ignored", 32'(mem_bus.mem_req | busy), 32'h0);

      access(0, F3_HU, 32'h106, 32'h0, 5'd13, 32'h80017FFF, 0, 0, o);
      check("lhu_data", load_data, 32'h00008001);

      access(1, F3_B, 32'h001, 32'h000000A5, 5'd0, 32'h0, 0, 0, o);
      check("sb_wstrb", 32'(o.strb), 32'h2);
      check("sb_wdata", o.wdata, 32'hA5A5A5A5);
      access(1, F3_W, 32'h010, 32'hCAFEF00D, 5'd0, 32'h0, 1, 0, o);
      check("sw_wstrb", 32'(o.strb), 32'hF);
      check("sw_wdata", o.wdata, 32'hCAFEF00D);

      access(1, 3'b011, 32'h020, 32'h0, 5'd0, 32'h0, -1, 0, o);
      check("st_illegal_fault", o.fault_c, 1);
      access(0, 3'b110, 32'h020, 32'h0, 5'd1, 32'h0, -1, 0, o);
      check("ld_illegal_fault", o.fault_c, 1);
      access(0, F3_W, 32'h020, 32'h0, 5'd0, 32'h12345678, 0, 0, o);
      check("x0_save_cycle", o.save_c, 2);
      check("x0_data", load_data, 32'h12345678);

      // Abandon a load while it waits in the request state.
      is_store = 1'b0; f3 = F3_W; addr = 32'h400; rd = 5'd8; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("pre_rst_req", 32'(mem_bus.mem_req), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_req", 32'(mem_bus.mem_req), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_data", load_data, 32'h0);
      check("mid_rst_pulses", 32'({done, fault, save}), 32'h0);
      repeat (2) tick();
      access(0, F3_W, 32'h400, 32'h0, 5'd8, 32'h0BADF00D, 1, 0, o);
      check("post_rst_done", o.done_c, 3);
      check("post_rst_data", load_data, 32'h0BADF00D);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

endmodule
